data_mem_ctrl: RTL and testbench

//  MEM-stage data-memory responder. Sits downstream of the EX/MEM pipeline register.

---
 rtl/data_mem_ctrl_if.sv | 31 +++
 rtl/data_mem_ctrl.sv | 139 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Backing-memory req/ack port used by the MEM-stage data-memory controller.
// The controller takes the master modport. The memory model takes the slave modport.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_ack_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory responder.
// Each load or store from EX/MEM becomes one req/ack access on the backing memory.
// The pipeline is stalled until the access reaches DONE.
// Optional feature macro: LAST_READ_BYPASS_EN. It adds a one-entry last-read buffer.
// A load that hits this buffer completes without a memory access.
module data_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [ADDR_W-1:0]    Addr_i,
  input  logic [DATA_W-1:0]    WriteData_i,
  output logic [DATA_W-1:0]    ReadData_o,
  output logic                 stall_o,
  data_mem_ctrl_if.master      mem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                w_stall;
  logic                w_request;
  logic                w_isLoad;
  logic                w_hit;
  logic [DATA_W-1:0]   w_bufData;
  logic                w_unusedAddrBits;

  logic                r_memReq;
  logic                r_memWe;
  logic [ADDR_W-1:0]   r_memAddr;
  logic [DATA_W-1:0]   r_memWdata;
  logic [DATA_W-1:0]   r_readData;

  // A request is any load or store. A store always wins when both are set.
  assign w_request        = MemRead_i | MemWrite_i;
  assign w_isLoad         = MemRead_i & ~MemWrite_i;
  assign w_unusedAddrBits = ^Addr_i[1:0];

`ifdef LAST_READ_BYPASS_EN
  logic                r_bufValid;
  logic [ADDR_W-3:0]   r_bufTag;
  logic [DATA_W-1:0]   r_bufData;

  assign w_hit     = (r_state == IDLE) && w_isLoad && r_bufValid &&
                     (r_bufTag == Addr_i[ADDR_W-1:2]);
  assign w_bufData = r_bufData;

  // Last-read buffer: filled by every completed load; written through by matching stores
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_bufValid <= 1'b0;
      r_bufTag   <= '0;
      r_bufData  <= '0;
    end else if ((r_state == BUSY) && mem.mem_ack_i) begin
      if (!r_memWe) begin
        r_bufValid <= 1'b1;
        r_bufTag   <= r_memAddr[ADDR_W-1:2];
        r_bufData  <= mem.mem_rdata_i;
      end else if (r_bufValid && (r_bufTag == r_memAddr[ADDR_W-1:2])) begin
        r_bufData  <= r_memWdata;
      end
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_bufData = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // Next-state and stall decode; DONE releases the pipeline and never re-issues
  always_comb begin
    w_nextState = r_state;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_request) begin
          w_stall     = 1'b1;
          w_nextState = w_hit ? DONE : BUSY;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (mem.mem_ack_i) w_nextState = DONE;
      end
      DONE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Memory-port registers and load-data register; held stable across BUSY until the ack
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_readData <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_request) begin
            if (w_hit) begin
              r_readData <= w_bufData;
            end else begin
              r_memReq   <= 1'b1;
              r_memWe    <= MemWrite_i;
              r_memAddr  <= {Addr_i[ADDR_W-1:2], 2'b00};
              r_memWdata <= WriteData_i;
            end
          end
        end
        BUSY: begin
          if (mem.mem_ack_i) begin
            r_memReq <= 1'b0;
            if (!r_memWe) r_readData <= mem.mem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_o         = rst_n_i & w_stall;
  assign ReadData_o      = r_readData;
  assign mem.mem_req_o   = r_memReq;
  assign mem.mem_we_o    = r_memWe;
  assign mem.mem_addr_o  = r_memAddr;
  assign mem.mem_wdata_o = r_memWdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl.
// It uses table vectors, hand-written reset sequences and random accesses.
// The random accesses are checked against a spec-level model.
// The bypass sequence is compiled only when LAST_READ_BYPASS_EN is defined.
module tb_data_mem_ctrl;

`ifdef LAST_READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] ReadData;
  logic        stall;

  int errCount   = 0;
  int checkCount = 0;

  // Reference model state: last architecturally visible load data and the last-read buffer
  logic [31:0] modelRead;
  bit          modelBufValid;
  logic [29:0] modelBufWord;
  logic [31:0] modelBufData;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nBusy;
    logic [31:0] rdata;
    logic [31:0] expRead;
    int          expStall;
  } vec_t;

  vec_t vecs[6];

  data_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus();

  data_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n_i    (rst_n),
    .MemRead_i  (MemRead),
    .MemWrite_i (MemWrite),
    .Addr_i     (Addr),
    .WriteData_i(WData),
    .ReadData_o (ReadData),
    .stall_o    (stall),
    .mem        (bus)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the DUT wedges the bench
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Spec-level model: returns expected stall length, whether memory is touched, and load data
  task automatic modelAccess(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int nBusy, input logic [31:0] rdata,
                             output int expStall, output logic expReq, output logic [31:0] expRead);
    bit hit;
    hit = BYPASS && modelBufValid && (modelBufWord == addr[31:2]);
    if (!rd && !wr) begin
      expStall = 0;
      expReq   = 1'b0;
    end else if (wr) begin
      expStall = 1 + nBusy;
      expReq   = 1'b1;
      if (hit) modelBufData = wdata;
    end else if (hit) begin
      expStall  = 1;
      expReq    = 1'b0;
      modelRead = modelBufData;
    end else begin
      expStall      = 1 + nBusy;
      expReq        = 1'b1;
      modelRead     = rdata;
      modelBufValid = 1'b1;
      modelBufWord  = addr[31:2];
      modelBufData  = rdata;
    end
    expRead = modelRead;
  endtask

  // Drives one instruction into the controller and plays the backing memory for it
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input int nBusy, input logic [31:0] rdata,
                               output int stallCycles, output logic sawReq,
                               output logic [31:0] reqAddr, output logic reqWe,
                               output logic [31:0] reqWdata, output logic [31:0] readOut,
                               output logic reqInDone, output logic timedOut);
    int busyCount;
    stallCycles = 0;
    sawReq      = 1'b0;
    reqAddr     = '0;
    reqWe       = 1'b0;
    reqWdata    = '0;
    reqInDone   = 1'b0;
    timedOut    = 1'b1;
    busyCount   = 0;
    @(posedge clk); #1;
    MemRead  = rd;
    MemWrite = wr;
    Addr     = addr;
    WData    = wdata;
    @(negedge clk);
    for (int c = 0; c < 64; c++) begin
      if (!stall) begin
        timedOut = 1'b0;
        break;
      end
      stallCycles++;
      if (bus.mem_req_o) begin
        if (!sawReq) begin
          reqAddr  = bus.mem_addr_o;
          reqWe    = bus.mem_we_o;
          reqWdata = bus.mem_wdata_o;
        end
        sawReq = 1'b1;
        busyCount++;
        if (busyCount == nBusy) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = rdata;
        end
      end
      @(posedge clk); #1;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = $urandom;
      @(negedge clk);
    end
    readOut   = ReadData;
    reqInDone = bus.mem_req_o;
    @(posedge clk); #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  // Runs one access and checks it against the model
  task automatic runAndCheck(input string tag, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int nBusy, input logic [31:0] rdata);
    int          expStall, stallCycles;
    logic        expReq, sawReq, reqWe, reqInDone, timedOut;
    logic [31:0] expRead, reqAddr, reqWdata, readOut;
    modelAccess(rd, wr, addr, wdata, nBusy, rdata, expStall, expReq, expRead);
    applyStimulus(rd, wr, addr, wdata, nBusy, rdata, stallCycles, sawReq, reqAddr,
                  reqWe, reqWdata, readOut, reqInDone, timedOut);
    checkOutput({tag, " timeout"}, 32'(timedOut), 32'd0);
    checkOutput({tag, " stall"}, stallCycles, expStall);
    checkOutput({tag, " req"}, 32'(sawReq), 32'(expReq));
    if (expReq) begin
      checkOutput({tag, " addr"}, reqAddr, {addr[31:2], 2'b00});
      checkOutput({tag, " we"}, 32'(reqWe), 32'(wr));
      if (wr) checkOutput({tag, " wdata"}, reqWdata, wdata);
    end
    checkOutput({tag, " rdata"}, readOut, expRead);
    checkOutput({tag, " reqInDone"}, 32'(reqInDone), 32'd0);
  endtask

  initial begin
    int          stallCycles;
    logic        sawReq, reqWe, reqInDone, timedOut;
    logic [31:0] reqAddr, reqWdata, readOut;
    int          dummyStall;
    logic        dummyReq;
    logic [31:0] dummyRead;

    rst_n           = 1'b1;
    MemRead         = 1'b1;
    MemWrite        = 1'b0;
    Addr            = 32'h0;
    WData           = 32'h0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'h0;
    modelRead       = 32'h0;
    modelBufValid   = 1'b0;
    modelBufWord    = '0;
    modelBufData    = '0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,          3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0203, 32'h0000_1234, 1, 32'h5555_5555, 32'hDEAD_BEEF, 2};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0500, 32'h0,          1, 32'h0,          32'hDEAD_BEEF, 0};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 2, 32'h7777_7777, 32'hDEAD_BEEF, 3};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_030C, 32'h0,          1, 32'h0BAD_F00D, 32'h0BAD_F00D, 2};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,          5, 32'h1111_2222, 32'h1111_2222, 6};

    // Reset held with a pending load: no stall, no request, cleared registers, ack ignored
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst stall", 32'(stall), 32'd0);
    checkOutput("rst req", 32'(bus.mem_req_o), 32'd0);
    checkOutput("rst rdata", ReadData, 32'd0);
    checkOutput("rst addr", bus.mem_addr_o, 32'd0);
    @(posedge clk); #1 bus.mem_ack_i = 1'b1;
    @(negedge clk);
    checkOutput("rst ack stall", 32'(stall), 32'd0);
    checkOutput("rst ack req", 32'(bus.mem_req_o), 32'd0);
    bus.mem_ack_i = 1'b0;
    MemRead       = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Table vectors: fixed expectations, model kept in step for later phases
    for (int i = 0; i < 6; i++) begin
      modelAccess(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].nBusy,
                  vecs[i].rdata, dummyStall, dummyReq, dummyRead);
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].nBusy,
                    vecs[i].rdata, stallCycles, sawReq, reqAddr, reqWe, reqWdata, readOut,
                    reqInDone, timedOut);
      checkOutput($sformatf("vec%0d timeout", i), 32'(timedOut), 32'd0);
      checkOutput($sformatf("vec%0d stall", i), stallCycles, vecs[i].expStall);
      checkOutput($sformatf("vec%0d rdata", i), readOut, vecs[i].expRead);
      if (vecs[i].rd || vecs[i].wr) begin
        checkOutput($sformatf("vec%0d addr", i), reqAddr, {vecs[i].addr[31:2], 2'b00});
        checkOutput($sformatf("vec%0d we", i), 32'(reqWe), 32'(vecs[i].wr));
        if (vecs[i].wr) checkOutput($sformatf("vec%0d wdata", i), reqWdata, vecs[i].wdata);
      end else begin
        checkOutput($sformatf("vec%0d noreq", i), 32'(sawReq), 32'd0);
      end
    end

    // Reset while BUSY: request and stall drop at once; stale ack afterwards is ignored
    @(posedge clk); #1;
    MemRead = 1'b1;
    Addr    = 32'h0000_0600;
    @(posedge clk); #1;
    checkOutput("busy req", 32'(bus.mem_req_o), 32'd1);
    checkOutput("busy stall", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst req", 32'(bus.mem_req_o), 32'd0);
    checkOutput("midrst stall", 32'(stall), 32'd0);
    checkOutput("midrst rdata", ReadData, 32'd0);
    MemRead = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    modelRead     = 32'h0;
    modelBufValid = 1'b0;
    @(posedge clk); #1 bus.mem_ack_i = 1'b1;
    @(posedge clk); #1 bus.mem_ack_i = 1'b0;
    @(negedge clk);
    checkOutput("stale ack stall", 32'(stall), 32'd0);
    checkOutput("stale ack req", 32'(bus.mem_req_o), 32'd0);
    checkOutput("stale ack rdata", ReadData, 32'd0);
    runAndCheck("post-rst read", 1'b1, 1'b0, 32'h0000_0700, 32'h0, 2, 32'h55AA_55AA);

`ifdef LAST_READ_BYPASS_EN
    // Load, write-through store to the same word, then a load served from the buffer
    runAndCheck("byp read", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0000_00AA);
    runAndCheck("byp write", 1'b0, 1'b1, 32'h0000_0040, 32'h0000_00BB, 1, 32'h0);
    runAndCheck("byp hit", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0000_00CC);
`endif

    // Random mix over a small address window so buffer hits and write-throughs occur
    for (int i = 0; i < 40; i++) begin
      int          kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 3));
      a    = 32'h40 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
      runAndCheck($sformatf("rnd%0d", i), kind[0], kind[1], a, $urandom,
                  int'($urandom_range(1, 4)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
